// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns engine: accepts one 128-bit state, transforms
// COLS_PER_CYCLE columns per clock in place, then holds the result for handoff.
module inv_mix_columns_seq #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int unsigned NCOL  = 4;
    localparam int unsigned COLW  = 32;
    localparam int unsigned IDXW  = 2;

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
        $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fsm_e;

    // GF(2^8) doubling modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a constant with bit3 set (09/0B/0D/0E): 8*a plus selected 4*a, 2*a, a
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? a : 8'h00);
    endfunction

    // One column, row 0 in the top byte
    function automatic logic [COLW-1:0] inv_mix_col(input logic [COLW-1:0] c);
        logic [7:0] s0;
        logic [7:0] s1;
        logic [7:0] s2;
        logic [7:0] s3;
        s0 = c[31:24];
        s1 = c[23:16];
        s2 = c[15:8];
        s3 = c[7:0];
        return {gmul(s0, 4'he) ^ gmul(s1, 4'hb) ^ gmul(s2, 4'hd) ^ gmul(s3, 4'h9),
                gmul(s0, 4'h9) ^ gmul(s1, 4'he) ^ gmul(s2, 4'hb) ^ gmul(s3, 4'hd),
                gmul(s0, 4'hd) ^ gmul(s1, 4'h9) ^ gmul(s2, 4'he) ^ gmul(s3, 4'hb),
                gmul(s0, 4'hb) ^ gmul(s1, 4'hd) ^ gmul(s2, 4'h9) ^ gmul(s3, 4'he)};
    endfunction

    fsm_e                            fsm_q, fsm_d;
    logic [IDXW-1:0]                 col_q, col_d;
    logic [NCOL-1:0][COLW-1:0]       st_q, st_d;
    logic                            in_ready_q, in_ready_d;
    logic                            out_valid_q, out_valid_d;
    logic                            busy_q, busy_d;
    logic [IDXW-1:0]                 cidx;
    logic                            last_c;

    // Column c sits at packed index NCOL-1-c so column 0 occupies the top 32 bits
    always_comb begin
        fsm_d  = fsm_q;
        col_d  = col_q;
        st_d   = st_q;
        cidx   = '0;
        last_c = ((3'(col_q) + 3'(COLS_PER_CYCLE)) == 3'(NCOL));

        unique case (fsm_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    st_d  = in_state;
                    col_d = '0;
                    fsm_d = CALC;
                end
            end
            CALC: begin
                for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
                    cidx = col_q + IDXW'(k);
                    st_d[IDXW'(NCOL - 1) - cidx] = inv_mix_col(st_q[IDXW'(NCOL - 1) - cidx]);
                end
                col_d = col_q + IDXW'(COLS_PER_CYCLE);
                if (last_c) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase

        in_ready_d  = (fsm_d == IDLE);
        out_valid_d = (fsm_d == DONE);
        busy_d      = (fsm_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            col_q       <= '0;
            st_q        <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            col_q       <= col_d;
            st_q        <= st_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_state = st_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq: three instances (1, 2 and 4 columns
// per cycle) checked against hand values and an independent GF(2^8) model.
module tb_inv_mix_columns_seq;

    localparam int unsigned NDUT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid  [NDUT];
    logic         in_ready  [NDUT];
    logic [127:0] in_state  [NDUT];
    logic         out_valid [NDUT];
    logic         out_ready [NDUT];
    logic [127:0] out_state [NDUT];
    logic         busy      [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        inv_mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g]),
            .busy      (busy[g])
        );
    end

    int n_vec;
    int n_err;

    localparam logic [127:0] FIPS_IN  = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] KC_IN    = {4{32'h8e4da1bc}};
    localparam logic [127:0] KC_OUT   = {4{32'hdb135345}};
    localparam logic [127:0] ONES     = {4{32'h01010101}};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Shift-and-add multiply, independent of any fixed-coefficient shortcut
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s, input bit inv);
        logic [15:0][7:0] b;
        logic [15:0][7:0] r;
        logic [7:0]       coef [4];
        logic [7:0]       acc;
        b = s;
        if (inv) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gf_mul(coef[2'(j - row)], b[4'(15 - 4 * c - j)]);
                end
                r[4'(15 - 4 * c - row)] = acc;
            end
        end
        return r;
    endfunction

    task automatic wait_ready(input int d, input string tag);
        for (int i = 0; i < 20; i++) begin
            if (in_ready[d]) break;
            step();
        end
        chk({tag, " in_ready"}, 128'(in_ready[d]), 128'(1));
    endtask

    task automatic wait_out(input int d, input string tag, output int n);
        n = 0;
        while (!out_valid[d] && n < 20) begin
            step();
            n++;
        end
        chk({tag, " out_valid"}, 128'(out_valid[d]), 128'(1));
    endtask

    // Accept one state, measure latency, check result and the completion handshake
    task automatic run(input int d, input logic [127:0] s, input logic [127:0] exp,
                       input int lat, input string tag);
        int  n;
        bit  rdy_seen;
        wait_ready(d, tag);
        in_valid[d] = 1'b1;
        in_state[d] = s;
        step();
        in_valid[d] = 1'b0;
        in_state[d] = '0;
        chk({tag, " busy"}, 128'(busy[d]), 128'(1));
        n = 0;
        rdy_seen = 1'b0;
        while (!out_valid[d] && n < 20) begin
            if (in_ready[d]) rdy_seen = 1'b1;
            step();
            n++;
        end
        chk({tag, " latency"}, 128'(n), 128'(lat));
        chk({tag, " ready low in calc"}, 128'(rdy_seen), 128'(0));
        chk({tag, " result"}, out_state[d], exp);
        out_ready[d] = 1'b1;
        step();
        out_ready[d] = 1'b0;
        chk({tag, " valid drop"}, 128'(out_valid[d]), 128'(0));
        chk({tag, " idle ready"}, 128'(in_ready[d]), 128'(1));
        chk({tag, " idle busy"}, 128'(busy[d]), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] vin  [8];
        logic [127:0] vexp [8];
        int  n;
        int  acc;
        int  outs;
        int  cyc;
        int  last_acc;
        bit  took;
        bit  stale;

        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            in_valid[d]  = 1'b0;
            in_state[d]  = '0;
            out_ready[d] = 1'b0;
        end

        // Reset values
        #12;
        for (int d = 0; d < NDUT; d++) begin
            chk("rst in_ready", 128'(in_ready[d]), 128'(0));
            chk("rst out_valid", 128'(out_valid[d]), 128'(0));
            chk("rst busy", 128'(busy[d]), 128'(0));
            chk("rst out_state", out_state[d], 128'(0));
        end
        rst_n = 1'b1;
        step();
        for (int d = 0; d < NDUT; d++) begin
            chk("post-rst in_ready", 128'(in_ready[d]), 128'(1));
        end

        // Known columns at every width; latency is 4 / columns-per-cycle
        run(0, FIPS_IN, FIPS_OUT, 4, "fips");
        for (int d = 0; d < NDUT; d++) begin
            run(d, KC_IN, KC_OUT, 4 >> d, "known col");
            run(d, ONES, ONES, 4 >> d, "ones");
            run(d, 128'(0), 128'(0), 4 >> d, "zero");
        end
        run(2, FIPS_IN, FIPS_OUT, 1, "fips x4");

        // Backpressure: result held for 10 cycles while a competing input waits
        wait_ready(0, "bp");
        in_valid[0] = 1'b1;
        in_state[0] = KC_IN;
        step();
        in_state[0] = FIPS_IN;
        wait_out(0, "bp", n);
        for (int i = 0; i < 10; i++) begin
            chk("bp hold state", out_state[0], KC_OUT);
            chk("bp hold valid", 128'(out_valid[0]), 128'(1));
            chk("bp in_ready", 128'(in_ready[0]), 128'(0));
            step();
        end
        out_ready[0] = 1'b1;
        step();
        out_ready[0] = 1'b0;
        chk("bp valid drop", 128'(out_valid[0]), 128'(0));
        chk("bp idle ready", 128'(in_ready[0]), 128'(1));
        step();
        in_valid[0] = 1'b0;
        chk("bp next accepted", 128'(busy[0]), 128'(1));
        wait_out(0, "bp next", n);
        chk("bp next latency", 128'(n), 128'(4));
        chk("bp next result", out_state[0], FIPS_OUT);
        out_ready[0] = 1'b1;
        step();
        out_ready[0] = 1'b0;

        // Back-to-back random states against the model and a forward round trip
        for (int i = 0; i < 8; i++) begin
            vin[i]  = {$urandom, $urandom, $urandom, $urandom};
            vexp[i] = mix(vin[i], 1'b1);
        end
        acc = 0;
        outs = 0;
        cyc = 0;
        last_acc = -1;
        in_valid[0]  = 1'b1;
        in_state[0]  = vin[0];
        out_ready[0] = 1'b1;
        while (outs < 8 && cyc < 200) begin
            took = in_valid[0] && in_ready[0];
            if (out_valid[0] && out_ready[0]) begin
                chk("b2b model", out_state[0], vexp[outs]);
                chk("b2b round trip", mix(out_state[0], 1'b0), vin[outs]);
                outs++;
            end
            if (took) begin
                if (last_acc >= 0) chk("b2b spacing", 128'(cyc - last_acc), 128'(4 + 2));
                last_acc = cyc;
                acc++;
            end
            step();
            cyc++;
            if (took) begin
                if (acc < 8) in_state[0] = vin[acc];
                else in_valid[0] = 1'b0;
            end
        end
        chk("b2b outputs", 128'(outs), 128'(8));
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        step();

        // Reset during the second CALC cycle
        wait_ready(0, "mid-rst");
        in_valid[0] = 1'b1;
        in_state[0] = FIPS_IN;
        step();
        in_valid[0] = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("mid-rst out_valid", 128'(out_valid[0]), 128'(0));
        chk("mid-rst busy", 128'(busy[0]), 128'(0));
        chk("mid-rst out_state", out_state[0], 128'(0));
        chk("mid-rst in_ready", 128'(in_ready[0]), 128'(0));
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("rel in_ready pre-edge", 128'(in_ready[0]), 128'(0));
        step();
        chk("rel in_ready", 128'(in_ready[0]), 128'(1));
        stale = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid[0]) stale = 1'b1;
            step();
        end
        chk("no stale out_valid", 128'(stale), 128'(0));
        run(0, FIPS_IN, FIPS_OUT, 4, "post-rst fips");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inv_mix_columns_seq.md
Name: inv_mix_columns_seq

Overview:
- Iterative AES InvMixColumns engine for the decryption datapath; the inverse of the forward MixColumns built on gf_mult.
- Accepts one 128-bit state over a valid/ready handshake.
- Processes COLS_PER_CYCLE columns per clock using GF(2^8) multiplies by 0x0E/0x0B/0x0D/0x09, then presents the result on a valid/ready output.
- Sits between InvShiftRows/InvSubBytes/AddRoundKey stages of the AES-256 decrypt round loop.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per CALC cycle. Legal values are 1, 2, 4. Any other value must cause an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input state presented
- in_ready  output  1  block can accept a state
- in_state  input  128  state; byte k = in_state[127-8k -: 8]; column c = bytes 4c..4c+3 (row 0 first)
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- out_state  output  128  transformed state, same byte ordering
- busy  output  1  high in CALC or DONE

Behaviour:
- Reset is asynchronous and active-low: clk plus rst_n. While rst_n=0:
  - FSM goes to IDLE.
  - Column counter and state register go to 0.
  - in_ready=0 during reset; it goes to 1 in the first cycle after deassertion.
  - out_valid=0, out_state=0, busy=0.
- FSM states are IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a rising edge: load in_state into the internal state register, set col=0, go to CALC.
- CALC:
  - in_ready=0.
  - Each edge replaces columns col..col+COLS_PER_CYCLE-1 in place with their InvMixColumns result:
    - r0=0E*s0^0B*s1^0D*s2^09*s3
    - r1=09*s0^0E*s1^0B*s2^0D*s3
    - r2=0D*s0^09*s1^0E*s2^0B*s3
    - r3=0B*s0^0D*s1^09*s2^0E*s3
  - After each edge, col += COLS_PER_CYCLE. The edge that processes column 3 moves the FSM to DONE.
  - Column processing order is 0→3.
- GF arithmetic:
  - Multiplication uses modulus x^8+x^4+x^3+x+1 (0x11B).
  - xtime is shift-left, then XOR 0x1B when the original bit7 was 1.
  - All results are 8-bit exact; no truncation beyond the field.
  - Multipliers are combinational inside this block, with constant-coefficient decomposition (09=8^1, 0B=8^2^1, 0D=8^4^1, 0E=8^4^2).
- Latency: 4/COLS_PER_CYCLE edges from the accept edge to out_valid rising (4, 2 or 1).
- DONE:
  - out_valid=1 and out_state = state register.
  - out_state must hold stable while out_valid&&!out_ready (backpressure of any length).
  - On out_valid&&out_ready: go to IDLE, out_valid drops next cycle.
  - out_state keeps its last value after completion; it is only meaningful while out_valid=1.
- in_valid while not in IDLE is ignored. No input is lost, because the producer must hold it until in_ready.
- The minimum input-to-input spacing is latency+2 cycles: accept, CALC×N, DONE with out_ready=1, then back to IDLE.
- Reset asserted mid-CALC or mid-DONE:
  - Immediate abort with all outputs at reset values.
  - The partial result is discarded and never presented.
- No X on any output after reset, regardless of in_state contents.

Test Plan:
- FIPS-197 round-1 state, COLS_PER_CYCLE=1: in_state=046681e5e0cb199a48f8d37a2806264c → out_state=d4bf5d30e0b452aeb84111f11e2798e5. out_valid rises exactly 4 cycles after the accept edge; in_ready=0 throughout.
- Known columns, repeated in all four columns: [DB,13,53,45]→[8E,4D,A1,BC]^-1, i.e. in 8e4da1bc ×4 → out db135345 ×4. Also 01010101 ×4 → unchanged (0E^0B^0D^09=01). Also all-zero → all-zero. Run with COLS_PER_CYCLE=1, 2 and 4; latencies must be 4, 2 and 1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. out_state must stay stable and in_ready=0; a new in_valid during this period is not accepted. Then out_ready=1 → one handshake, IDLE the next cycle, the next state is accepted, and its result is correct.
- Back-to-back: 8 random states with in_valid held high and out_ready=1. Every output must equal a software InvMixColumns model. Each output must also equal the original after the test bench applies forward MixColumns (via gf_mult ×02/×03) to the result. Spacing must be latency+2 cycles.
- Reset mid-operation: assert rst_n=0 during the 2nd CALC cycle. out_valid, busy and out_state must go to 0 immediately. After release, in_ready=1 next cycle and no stale out_valid ever appears. The next block 046681e5... still yields d4bf5d30....
